// File: rtl/mmio_uart_tx_pkg.sv
// Shared register offsets, STATUS bit positions and TX FSM states for the MMIO UART.
package mmio_uart_tx_pkg;

    localparam logic [15:0] ADDR_DATA   = 16'h0020;
    localparam logic [15:0] ADDR_STATUS = 16'h0024;

    localparam int unsigned ST_FULL      = 0;
    localparam int unsigned ST_EMPTY     = 1;
    localparam int unsigned ST_ACTIVE    = 2;
    localparam int unsigned ST_OVERFLOW  = 3;
    localparam int unsigned ST_PARITY    = 4;
    localparam int unsigned ST_COUNT_LSB = 8;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// Parameterised synchronous FIFO; pointers carry an extra wrap bit so full/empty need no flag.
module uart_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Push and pop are qualified by start-of-cycle full/empty, so a write into
    // an empty FIFO only becomes poppable on the following cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count = wr_ptr - rd_ptr;
    assign dout  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!nreset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// MMIO-fed 8N1 UART transmitter with FIFO and sticky overflow flag.
// Define MMIO_UART_PARITY_EN to insert an even-parity bit between data and stop.
module mmio_uart_tx
    import mmio_uart_tx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned FIFO_DEPTH   = 16
) (
    input  logic                          clk,
    input  logic                          nreset,
    input  logic [15:0]                   mmio_addr,
    input  logic [31:0]                   mmio_wdata,
    input  logic                          mmio_we,
    input  logic                          mmio_re,
    output logic [31:0]                   mmio_rdata,
    output logic                          uart_tx,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int unsigned BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_RELOAD = BW'(CLKS_PER_BIT - 1);

    tx_state_t     state, state_n;
    logic [BW-1:0] baud, baud_n;
    logic [2:0]    bit_idx, bit_idx_n;
    logic [7:0]    shift, shift_n;
    logic          tx, tx_n;
    logic          pop;
    logic          full, empty;
    logic [7:0]    fifo_dout;
    logic          overflow;
    logic          wr_data, wr_status;
    logic [31:0]   read_word;
    logic          unused_wdata;

    assign wr_data      = mmio_we && (mmio_addr == ADDR_DATA);
    assign wr_status    = mmio_we && (mmio_addr == ADDR_STATUS);
    assign unused_wdata = ^mmio_wdata[31:8];

    uart_sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .nreset (nreset),
        .push   (wr_data),
        .pop    (pop),
        .din    (mmio_wdata[7:0]),
        .dout   (fifo_dout),
        .full   (full),
        .empty  (empty),
        .count  (fifo_count)
    );

`ifdef MMIO_UART_PARITY_EN
    logic parity, parity_n;
`endif

    always_comb begin
        state_n   = state;
        baud_n    = baud;
        bit_idx_n = bit_idx;
        shift_n   = shift;
        tx_n      = tx;
        pop       = 1'b0;
`ifdef MMIO_UART_PARITY_EN
        parity_n  = parity;
`endif
        case (state)
            TX_IDLE: begin
                tx_n = 1'b1;
                if (!empty) begin
                    pop     = 1'b1;
                    shift_n = fifo_dout;
`ifdef MMIO_UART_PARITY_EN
                    parity_n = ^fifo_dout;
`endif
                    baud_n  = BAUD_RELOAD;
                    tx_n    = 1'b0;
                    state_n = TX_START;
                end
            end
            TX_START: begin
                if (baud == '0) begin
                    baud_n    = BAUD_RELOAD;
                    bit_idx_n = '0;
                    tx_n      = shift[0];
                    state_n   = TX_DATA;
                end else begin
                    baud_n = baud - 1'b1;
                end
            end
            TX_DATA: begin
                if (baud == '0) begin
                    baud_n = BAUD_RELOAD;
                    if (bit_idx == 3'd7) begin
`ifdef MMIO_UART_PARITY_EN
                        tx_n    = parity;
                        state_n = TX_PARITY;
`else
                        tx_n    = 1'b1;
                        state_n = TX_STOP;
`endif
                    end else begin
                        // tx is loaded with the next bit while the register shifts.
                        bit_idx_n = bit_idx + 3'd1;
                        shift_n   = {1'b0, shift[7:1]};
                        tx_n      = shift[1];
                    end
                end else begin
                    baud_n = baud - 1'b1;
                end
            end
`ifdef MMIO_UART_PARITY_EN
            TX_PARITY: begin
                if (baud == '0) begin
                    baud_n  = BAUD_RELOAD;
                    tx_n    = 1'b1;
                    state_n = TX_STOP;
                end else begin
                    baud_n = baud - 1'b1;
                end
            end
`endif
            TX_STOP: begin
                if (baud == '0) begin
                    tx_n    = 1'b1;
                    state_n = TX_IDLE;
                end else begin
                    baud_n = baud - 1'b1;
                end
            end
            default: begin
                tx_n    = 1'b1;
                state_n = TX_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            state   <= TX_IDLE;
            baud    <= '0;
            bit_idx <= '0;
            shift   <= '0;
            tx      <= 1'b1;
`ifdef MMIO_UART_PARITY_EN
            parity  <= 1'b0;
`endif
        end else begin
            state   <= state_n;
            baud    <= baud_n;
            bit_idx <= bit_idx_n;
            shift   <= shift_n;
            tx      <= tx_n;
`ifdef MMIO_UART_PARITY_EN
            parity  <= parity_n;
`endif
        end
    end

    always_comb begin
        read_word = '0;
        if (mmio_addr == ADDR_STATUS) begin
            read_word[ST_FULL]     = full;
            read_word[ST_EMPTY]    = empty;
            read_word[ST_ACTIVE]   = (state != TX_IDLE);
            read_word[ST_OVERFLOW] = overflow;
`ifdef MMIO_UART_PARITY_EN
            read_word[ST_PARITY]   = 1'b1;
`endif
            read_word[ST_COUNT_LSB +: 8] = 8'(fifo_count);
        end
    end

    // A rejected push outranks a clear landing in the same cycle.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            overflow   <= 1'b0;
            mmio_rdata <= '0;
        end else begin
            if (wr_data && full)
                overflow <= 1'b1;
            else if (wr_status && mmio_wdata[ST_OVERFLOW])
                overflow <= 1'b0;
            if (mmio_re)
                mmio_rdata <= read_word;
        end
    end

    assign uart_tx = tx;
    assign tx_busy = !empty || (state != TX_IDLE);

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed self-checking bench for mmio_uart_tx (CLKS_PER_BIT=4, FIFO_DEPTH=4).
module tb_mmio_uart_tx;

    localparam int CPB = 4;
`ifdef MMIO_UART_PARITY_EN
    localparam int          NBITS = 11;
    localparam logic [31:0] PAR   = 32'h10;
`else
    localparam int          NBITS = 10;
    localparam logic [31:0] PAR   = 32'h0;
`endif
    localparam int FRAME = CPB * NBITS;

    logic        clk = 1'b0;
    logic        nreset;
    logic [15:0] mmio_addr;
    logic [31:0] mmio_wdata;
    logic        mmio_we;
    logic        mmio_re;
    logic [31:0] mmio_rdata;
    logic        uart_tx;
    logic        tx_busy;
    logic [2:0]  fifo_count;

    int cyc = 0;
    int errors = 0;
    int checks = 0;

    mmio_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (4)
    ) dut (
        .clk        (clk),
        .nreset     (nreset),
        .mmio_addr  (mmio_addr),
        .mmio_wdata (mmio_wdata),
        .mmio_we    (mmio_we),
        .mmio_re    (mmio_re),
        .mmio_rdata (mmio_rdata),
        .uart_tx    (uart_tx),
        .tx_busy    (tx_busy),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic frame_bit(input logic [7:0] b, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return b[idx-1];
`ifdef MMIO_UART_PARITY_EN
        if (idx == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    // Call at the negedge where frame cycle 'first' is visible; returns at the negedge after the frame.
    task automatic expect_frame(input logic [7:0] b, input int first);
        for (int i = first; i < FRAME; i++) begin
            check($sformatf("frame_%02h_c%0d", b, i), {31'b0, uart_tx}, {31'b0, frame_bit(b, i / CPB)});
            @(negedge clk);
        end
    endtask

    task automatic mmio_write(input logic [15:0] a, input logic [31:0] d);
        mmio_addr  = a;
        mmio_wdata = d;
        mmio_we    = 1'b1;
        @(negedge clk);
        mmio_we    = 1'b0;
    endtask

    task automatic mmio_read(input logic [15:0] a);
        mmio_addr = a;
        mmio_re   = 1'b1;
        @(negedge clk);
        mmio_re   = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        int n;
        n = 0;
        while (tx_busy && n < limit) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", {31'b0, tx_busy}, 32'h0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        logic bad;
        nreset = 1'b0; mmio_addr = '0; mmio_wdata = '0; mmio_we = 1'b0; mmio_re = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tx",    {31'b0, uart_tx}, 32'h1);
        check("rst_rdata", mmio_rdata, 32'h0);
        check("rst_busy",  {31'b0, tx_busy}, 32'h0);
        check("rst_count", {29'b0, fifo_count}, 32'h0);
        nreset = 1'b1;
        @(negedge clk);

        // single byte 0xA5
        mmio_write(16'h0020, 32'hA5);
        check("single_idle_cycle", {31'b0, uart_tx}, 32'h1);
        check("single_busy",       {31'b0, tx_busy}, 32'h1);
        check("single_count",      {29'b0, fifo_count}, 32'h1);
        @(negedge clk);
        expect_frame(8'hA5, 0);
        check("single_end_tx",   {31'b0, uart_tx}, 32'h1);
        check("single_end_busy", {31'b0, tx_busy}, 32'h0);

        // register reads, idle and empty
        mmio_read(16'h0024);
        check("status_idle", mmio_rdata, 32'h2 | PAR);
        @(negedge clk);
        check("rdata_hold", mmio_rdata, 32'h2 | PAR);
        mmio_read(16'h0030);
        check("read_other", mmio_rdata, 32'h0);
        mmio_read(16'h0024);
        check("status_idle2", mmio_rdata, 32'h2 | PAR);
        mmio_read(16'h0020);
        check("read_data_reg", mmio_rdata, 32'h0);
        mmio_write(16'h0028, 32'h55);
        @(negedge clk);
        check("other_write_busy",  {31'b0, tx_busy}, 32'h0);
        check("other_write_count", {29'b0, fifo_count}, 32'h0);

        // queued status then in-frame status
        t0 = cyc;
        mmio_write(16'h0020, 32'h55);
        mmio_read(16'h0024);
        check("status_queued", mmio_rdata, 32'h100 | PAR);
        check("queued_start",  {31'b0, uart_tx}, 32'h0);
        mmio_write(16'h0020, 32'h11);
        mmio_write(16'h0020, 32'h22);
        mmio_read(16'h0024);
        check("status_active", mmio_rdata, 32'h204 | PAR);
        wait_idle(1000);
        check("three_frame_time", cyc - t0, 2 + FRAME + 2 * (FRAME + 1));

        // back-to-back 0x01, 0x02, 0x03
        mmio_addr = 16'h0020; mmio_wdata = 32'h01; mmio_we = 1'b1;
        @(negedge clk);
        check("b2b_count1", {29'b0, fifo_count}, 32'h1);
        mmio_wdata = 32'h02;
        @(negedge clk);
        check("b2b_count2", {29'b0, fifo_count}, 32'h1);
        check("b2b_start",  {31'b0, uart_tx}, 32'h0);
        mmio_wdata = 32'h03;
        @(negedge clk);
        mmio_we = 1'b0;
        check("b2b_peak", {29'b0, fifo_count}, 32'h2);
        expect_frame(8'h01, 1);
        check("b2b_gap1",  {31'b0, uart_tx}, 32'h1);
        check("b2b_cnt_gap", {29'b0, fifo_count}, 32'h2);
        @(negedge clk);
        expect_frame(8'h02, 0);
        check("b2b_gap2", {31'b0, uart_tx}, 32'h1);
        @(negedge clk);
        expect_frame(8'h03, 0);
        check("b2b_end_busy",  {31'b0, tx_busy}, 32'h0);
        check("b2b_end_count", {29'b0, fifo_count}, 32'h0);

        // overflow: six writes into a depth-4 FIFO
        t0 = cyc;
        for (int i = 0; i < 6; i++) mmio_write(16'h0020, 32'h10 + i);
        check("ovf_count", {29'b0, fifo_count}, 32'h4);
        mmio_read(16'h0024);
        check("ovf_status", mmio_rdata, 32'h40D | PAR);
        mmio_addr = 16'h0024; mmio_wdata = 32'h8; mmio_we = 1'b1; mmio_re = 1'b1;
        @(negedge clk);
        mmio_we = 1'b0; mmio_re = 1'b0;
        check("we_re_pre_write", mmio_rdata, 32'h40D | PAR);
        mmio_read(16'h0024);
        check("ovf_cleared", mmio_rdata, 32'h405 | PAR);
        wait_idle(2000);
        check("five_frame_time", cyc - t0, 2 + FRAME + 4 * (FRAME + 1));

        // one frame of 0x07 (parity bit 1 when enabled)
        mmio_write(16'h0020, 32'h07);
        @(negedge clk);
        expect_frame(8'h07, 0);
        check("f07_end_busy", {31'b0, tx_busy}, 32'h0);

        // reset during data bit 3
        mmio_write(16'h0020, 32'h5A);
        mmio_write(16'h0020, 32'h33);
        repeat (15) @(negedge clk);
        check("mid_bit2", {31'b0, uart_tx}, 32'h0);
        @(negedge clk);
        check("mid_bit3", {31'b0, uart_tx}, 32'h1);
        check("mid_count", {29'b0, fifo_count}, 32'h1);
        nreset = 1'b0;
        @(negedge clk);
        check("mid_rst_tx",    {31'b0, uart_tx}, 32'h1);
        check("mid_rst_count", {29'b0, fifo_count}, 32'h0);
        check("mid_rst_busy",  {31'b0, tx_busy}, 32'h0);
        check("mid_rst_rdata", mmio_rdata, 32'h0);
        nreset = 1'b1;
        bad = 1'b0;
        repeat (60) begin
            @(negedge clk);
            if (uart_tx !== 1'b1 || tx_busy !== 1'b0) bad = 1'b1;
        end
        check("no_resume", {31'b0, bad}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
